// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD command sequencer
package sd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CRC,
      ST_SEND,
      ST_WAIT_SEND,
      ST_POLL,
      ST_WAIT_POLL,
      ST_EXT,
      ST_WAIT_EXT,
      ST_RESP
   } sd_seq_state_t;

   localparam logic       SPI_OP_READ     = 1'b0;
   localparam logic       SPI_OP_WRITE    = 1'b1;
   localparam int         CMD_FRAME_BYTES = 6;
   localparam int         R1_POLL_SIZE    = 0;
   localparam int         EXT_BYTES       = 4;
   localparam int         CMD_BITS        = 40;
   localparam logic [6:0] CRC7_POLY       = 7'h09;

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// rtl/sd_cmd_sequencer_if.sv - command/response and spi_controller handshake bundle
interface sd_cmd_sequencer_if #(
   parameter int ADDR_W = 6
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic [5:0]        cmd_index;
   logic [31:0]       cmd_arg;
   logic              cmd_ext;
   logic              resp_valid;
   logic [7:0]        resp_r1;
   logic [31:0]       resp_ext;
   logic              resp_timeout;
   logic              spi_start;
   logic              spi_op;
   logic [ADDR_W-1:0] spi_size;
   logic [ADDR_W-1:0] spi_address;
   logic [7:0]        spi_data_in;
   logic [7:0]        spi_data_out;
   logic              spi_wr;
   logic              spi_done;

   modport master (
      input  cmd_valid, cmd_index, cmd_arg, cmd_ext,
      input  spi_address, spi_data_out, spi_wr, spi_done,
      output cmd_ready, resp_valid, resp_r1, resp_ext, resp_timeout,
      output spi_start, spi_op, spi_size, spi_data_in
   );

   modport slave (
      output cmd_valid, cmd_index, cmd_arg, cmd_ext,
      output spi_address, spi_data_out, spi_wr, spi_done,
      input  cmd_ready, resp_valid, resp_r1, resp_ext, resp_timeout,
      input  spi_start, spi_op, spi_size, spi_data_in
   );

endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero init
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc_out
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;
   logic       fb;

   always_comb begin
      fb    = bit_in ^ crc_q[6];
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_out = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - builds SPI-mode SD command frames and collects the R1/R3/R7 reply
module sd_cmd_sequencer
   import sd_pkg::*;
#(
   parameter int MEMORY_SIZE_IN_BYTES = 64,
   parameter int NCR_MAX              = 8
) (
   input logic                clk,
   input logic                rst,
   sd_cmd_sequencer_if.master bus
);

   localparam int ADDR_W = $clog2(MEMORY_SIZE_IN_BYTES);

   sd_seq_state_t state_q, state_d;
   logic [5:0]    index_q, index_d;
   logic [31:0]   arg_q, arg_d;
   logic          ext_q, ext_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    poll_cnt_q, poll_cnt_d;
   logic [7:0]    r1_q, r1_d;
   logic [31:0]   resp_ext_q, resp_ext_d;
   logic          timeout_q, timeout_d;

   logic          accept;
   logic [7:0]    poll_inc;
   logic          poll_last;
   logic [39:0]   cmd_bits;
   logic          crc_clr;
   logic          crc_en;
   logic          crc_bit;
   logic [6:0]    crc;
   logic [1:0]    ext_sel;

   assign accept    = bus.cmd_valid && (state_q == ST_IDLE);
   assign poll_inc  = poll_cnt_q + 8'd1;
   assign poll_last = (poll_inc == 8'(NCR_MAX));
   assign cmd_bits  = {2'b01, index_q, arg_q};
   assign crc_bit   = cmd_bits[6'(CMD_BITS - 1) - bit_cnt_q];
   // Response bytes arrive first-to-last; the first one lands in the top byte.
   assign ext_sel   = 2'd3 - bus.spi_address[1:0];

   sd_crc7 u_crc7 (
      .clk    (clk),
      .rst    (rst),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (crc_bit),
      .crc_out(crc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         index_q    <= '0;
         arg_q      <= '0;
         ext_q      <= 1'b0;
         bit_cnt_q  <= '0;
         poll_cnt_q <= '0;
         r1_q       <= 8'hFF;
         resp_ext_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         arg_q      <= arg_d;
         ext_q      <= ext_d;
         bit_cnt_q  <= bit_cnt_d;
         poll_cnt_q <= poll_cnt_d;
         r1_q       <= r1_d;
         resp_ext_q <= resp_ext_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (accept) state_d = ST_CRC;
         ST_CRC:       if (bit_cnt_q == 6'(CMD_BITS - 1)) state_d = ST_SEND;
         ST_SEND:      state_d = ST_WAIT_SEND;
         ST_WAIT_SEND: if (bus.spi_done) state_d = ST_POLL;
         ST_POLL:      state_d = ST_WAIT_POLL;
         ST_WAIT_POLL: begin
            if (bus.spi_done) begin
               if (!bus.spi_data_out[7]) begin
                  state_d = ext_q ? ST_EXT : ST_RESP;
               end else if (poll_last) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_POLL;
               end
            end
         end
         ST_EXT:       state_d = ST_WAIT_EXT;
         ST_WAIT_EXT:  if (bus.spi_done) state_d = ST_RESP;
         ST_RESP:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      index_d    = index_q;
      arg_d      = arg_q;
      ext_d      = ext_q;
      bit_cnt_d  = bit_cnt_q;
      poll_cnt_d = poll_cnt_q;
      r1_d       = r1_q;
      resp_ext_d = resp_ext_q;
      timeout_d  = timeout_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;

      if (accept) begin
         index_d   = bus.cmd_index;
         arg_d     = bus.cmd_arg;
         ext_d     = bus.cmd_ext;
         timeout_d = 1'b0;
         bit_cnt_d = '0;
         crc_clr   = 1'b1;
      end

      if (state_q == ST_CRC) begin
         crc_en    = 1'b1;
         bit_cnt_d = bit_cnt_q + 6'd1;
      end

      if (state_q == ST_WAIT_SEND && bus.spi_done) begin
         poll_cnt_d = '0;
      end

      if (state_q == ST_WAIT_POLL && bus.spi_done) begin
         poll_cnt_d = poll_inc;
         if (!bus.spi_data_out[7]) begin
            r1_d = bus.spi_data_out;
         end else if (poll_last) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
         end
      end

      if (state_q == ST_WAIT_EXT && bus.spi_wr) begin
         resp_ext_d[{ext_sel, 3'b000} +: 8] = bus.spi_data_out;
      end
   end

   // Transfer opcode and size are decoded from the state pair, so they stay put until spi_done.
   always_comb begin
      bus.cmd_ready  = (state_q == ST_IDLE);
      bus.resp_valid = (state_q == ST_RESP);
      bus.spi_start  = 1'b0;
      bus.spi_op     = SPI_OP_READ;
      bus.spi_size   = '0;
      case (state_q)
         ST_SEND, ST_WAIT_SEND: begin
            bus.spi_start = (state_q == ST_SEND);
            bus.spi_op    = SPI_OP_WRITE;
            bus.spi_size  = ADDR_W'(CMD_FRAME_BYTES - 1);
         end
         ST_POLL, ST_WAIT_POLL: begin
            bus.spi_start = (state_q == ST_POLL);
            bus.spi_size  = ADDR_W'(R1_POLL_SIZE);
         end
         ST_EXT, ST_WAIT_EXT: begin
            bus.spi_start = (state_q == ST_EXT);
            bus.spi_size  = ADDR_W'(EXT_BYTES - 1);
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.spi_data_in = 8'hFF;
      case (bus.spi_address)
         ADDR_W'(0): bus.spi_data_in = {2'b01, index_q};
         ADDR_W'(1): bus.spi_data_in = arg_q[31:24];
         ADDR_W'(2): bus.spi_data_in = arg_q[23:16];
         ADDR_W'(3): bus.spi_data_in = arg_q[15:8];
         ADDR_W'(4): bus.spi_data_in = arg_q[7:0];
         ADDR_W'(5): bus.spi_data_in = {crc, 1'b1};
         default: ;
      endcase
   end

   assign bus.resp_r1      = r1_q;
   assign bus.resp_ext     = resp_ext_q;
   assign bus.resp_timeout = timeout_q;

endmodule
